// File: rtl/gray_step_monitor_if.sv
// Bus bundle for gray_step_monitor.
//   q_in    : 2-bit Gray count from the upstream mod-4 counter (async to clk_50M)
//   clr     : synchronous clear of pos/err/err_cnt
//   step_p  : one-cycle pulse per valid single step
//   dir     : direction of the last valid step (1=forward)
//   pos     : wrapping step position
//   err     : sticky illegal-transition flag
//   err_cnt : saturating illegal-transition count
//   seg     : active-low 7-seg (g..a) hex of pos[3:0]
// master drives q_in/clr, slave is the monitor.
interface gray_step_monitor_if #(
  parameter int POS_W     = 8,
  parameter int ERR_CNT_W = 4
);
  logic [1:0]           q_in;
  logic                 clr;
  logic                 step_p;
  logic                 dir;
  logic [POS_W-1:0]     pos;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [6:0]           seg;

  modport master (
    output q_in, clr,
    input  step_p, dir, pos, err, err_cnt, seg
  );

  modport slave (
    input  q_in, clr,
    output step_p, dir, pos, err, err_cnt, seg
  );
endinterface

// File: rtl/gray_step_monitor.sv
// Quadrature-style monitor for a 2-bit Gray counter.
// Synchronizes q_in (s1, s2), keeps the previous synchronized value (s3),
// and classifies each s3->s2 transition as forward step, backward step,
// illegal double jump, or no change. Tracks a wrapping position, the last
// direction, a sticky error flag and a saturating error count; decodes
// pos[3:0] to an active-low hex seven-segment pattern.
// Ports: clk_50M, rst_n (async, active-low), bus (slave modport).
module gray_step_monitor #(
  parameter int POS_W     = 8,
  parameter int ERR_CNT_W = 4
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  gray_step_monitor_if.slave  bus
);

  logic [1:0]           s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic                 step_p_q, step_p_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]           delta;
  logic [6:0]           seg;

  // Gray code to position index along the forward sequence 00,10,11,01.
  function automatic logic [1:0] g2i(input logic [1:0] g);
    case (g)
      2'b00:   g2i = 2'd0;
      2'b10:   g2i = 2'd1;
      2'b11:   g2i = 2'd2;
      default: g2i = 2'd3;
    endcase
  endfunction

  // Mod-4 difference: 1 = forward, 3 = backward, 2 = illegal jump.
  assign delta = g2i(s2_q) - g2i(s3_q);

  always_comb begin
    s1_d      = bus.q_in;
    s2_d      = s1_q;
    s3_d      = s2_q;   // always advances so each transition is seen once
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_p_d  = 1'b0;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (bus.clr) begin
      // Clear wins over any event evaluated in the same cycle.
      pos_d     = '0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      case (delta)
        2'd1: begin
          pos_d    = pos_q + 1'b1;
          dir_d    = 1'b1;
          step_p_d = 1'b1;
        end
        2'd3: begin
          pos_d    = pos_q - 1'b1;
          dir_d    = 1'b0;
          step_p_d = 1'b1;
        end
        2'd2: begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 2'b00;
      s2_q      <= 2'b00;
      s3_q      <= 2'b00;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_p_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_p_q  <= step_p_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Active-low segments, bit order g..a.
  always_comb begin
    seg = 7'b1111111;
    case (pos_q[3:0])
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

  assign bus.step_p  = step_p_q;
  assign bus.dir     = dir_q;
  assign bus.pos     = pos_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.seg     = seg;

endmodule

// File: tb/tb_gray_step_monitor.sv
module tb_gray_step_monitor;
  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   step_cnt = 0;

  gray_step_monitor_if #(.POS_W(8), .ERR_CNT_W(4)) bus ();

  gray_step_monitor #(.POS_W(8), .ERR_CNT_W(4)) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;

  // step_p lasts one cycle, so one negedge sample per pulse
  always @(negedge clk_50M) if (bus.step_p === 1'b1) step_cnt++;

  task automatic hold(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic do_reset();
    @(negedge clk_50M);
    rst_n = 1'b0; bus.q_in = 2'b00; bus.clr = 1'b0;
    hold(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.q_in = 2'b00; bus.clr = 1'b0;
    hold(2);
    checks++; if (bus.step_p !== 1'b0) begin errors++; $display("FAIL rst_step_p: got %b exp 0", bus.step_p); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL rst_dir: got %b exp 1", bus.dir); end
    checks++; if (bus.pos !== 8'h00) begin errors++; $display("FAIL rst_pos: got %h exp 00", bus.pos); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", bus.err); end
    checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL rst_err_cnt: got %h exp 0", bus.err_cnt); end
    checks++; if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL rst_seg: got %b exp 1000000", bus.seg); end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    int s0;
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset();
    hold(4);
    s0 = step_cnt;
    for (int i = 0; i < 4; i++) begin bus.q_in = seq[i]; hold(8); end
    checks++; if (step_cnt - s0 !== 4) begin errors++; $display("FAIL fwd_steps: got %0d exp 4", step_cnt - s0); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL fwd_dir: got %b exp 1", bus.dir); end
    checks++; if (bus.pos !== 8'h04) begin errors++; $display("FAIL fwd_pos: got %h exp 04", bus.pos); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fwd_err: got %b exp 0", bus.err); end
    checks++; if (bus.seg !== 7'b0011001) begin errors++; $display("FAIL fwd_seg: got %b exp 0011001", bus.seg); end
  endtask

  task automatic test_backward_wrap();
    int s0;
    do_reset();
    hold(4);
    s0 = step_cnt;
    bus.q_in = 2'b01; hold(8);
    checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL bwd_steps: got %0d exp 1", step_cnt - s0); end
    checks++; if (bus.pos !== 8'hFF) begin errors++; $display("FAIL bwd_pos: got %h exp FF", bus.pos); end
    checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL bwd_dir: got %b exp 0", bus.dir); end
    checks++; if (bus.seg !== 7'b0001110) begin errors++; $display("FAIL bwd_seg: got %b exp 0001110", bus.seg); end
    bus.q_in = 2'b00; hold(8);
    checks++; if (bus.pos !== 8'h00) begin errors++; $display("FAIL wrap_pos: got %h exp 00", bus.pos); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL wrap_dir: got %b exp 1", bus.dir); end
  endtask

  task automatic test_illegal();
    int s0;
    do_reset();
    hold(4);
    s0 = step_cnt;
    bus.q_in = 2'b11; hold(8);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b exp 1", bus.err); end
    checks++; if (bus.err_cnt !== 4'h1) begin errors++; $display("FAIL ill_cnt: got %h exp 1", bus.err_cnt); end
    checks++; if (bus.pos !== 8'h00) begin errors++; $display("FAIL ill_pos: got %h exp 00", bus.pos); end
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL ill_steps: got %0d exp 0", step_cnt - s0); end
    for (int i = 0; i < 20; i++) begin bus.q_in = bus.q_in ^ 2'b11; hold(4); end
    checks++; if (bus.err_cnt !== 4'hF) begin errors++; $display("FAIL ill_sat: got %h exp F", bus.err_cnt); end
    checks++; if (bus.pos !== 8'h00) begin errors++; $display("FAIL ill_sat_pos: got %h exp 00", bus.pos); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL ill_dir: got %b exp 1", bus.dir); end
  endtask

  task automatic test_clear_collision();
    logic [1:0] seq [5];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    do_reset();
    hold(4);
    for (int i = 0; i < 5; i++) begin bus.q_in = seq[i]; hold(6); end
    bus.q_in = 2'b01; hold(6);    // idx 1 -> 3: illegal
    checks++; if (bus.pos !== 8'h05 || bus.err !== 1'b1) begin errors++; $display("FAIL clr_pre: got pos %h err %b exp 05 1", bus.pos, bus.err); end
    bus.q_in = 2'b00;             // forward step, evaluated two edges later
    hold(2);
    bus.clr = 1'b1;
    hold(1);
    bus.clr = 1'b0;
    checks++; if (bus.pos !== 8'h00) begin errors++; $display("FAIL clr_pos: got %h exp 00", bus.pos); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b exp 0", bus.err); end
    checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL clr_cnt: got %h exp 0", bus.err_cnt); end
    checks++; if (bus.step_p !== 1'b0) begin errors++; $display("FAIL clr_step_p: got %b exp 0", bus.step_p); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL clr_dir: got %b exp 1", bus.dir); end
    hold(4);
    bus.q_in = 2'b10; hold(6);
    checks++; if (bus.pos !== 8'h01) begin errors++; $display("FAIL clr_next: got %h exp 01", bus.pos); end
  endtask

  task automatic test_latency_reset();
    int s0;
    do_reset();
    hold(4);
    bus.q_in = 2'b10;
    @(negedge clk_50M);           // after edge N
    checks++; if (bus.step_p !== 1'b0) begin errors++; $display("FAIL lat_n: got %b exp 0", bus.step_p); end
    @(negedge clk_50M);           // after edge N+1
    checks++; if (bus.step_p !== 1'b0) begin errors++; $display("FAIL lat_n1: got %b exp 0", bus.step_p); end
    @(negedge clk_50M);           // after edge N+2
    checks++; if (bus.step_p !== 1'b1 || bus.pos !== 8'h01) begin errors++; $display("FAIL lat_n2: got step %b pos %h exp 1 01", bus.step_p, bus.pos); end
    @(negedge clk_50M);
    checks++; if (bus.step_p !== 1'b0) begin errors++; $display("FAIL lat_pulse: got %b exp 0", bus.step_p); end
    // reset lands while a transition is in the synchronizer
    do_reset();
    hold(4);
    s0 = step_cnt;
    bus.q_in = 2'b10;
    @(posedge clk_50M);           // edge N
    @(posedge clk_50M);           // edge N+1
    #1 rst_n = 1'b0;
    hold(3);
    checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL rstf_steps: got %0d exp 0", step_cnt - s0); end
    checks++; if (bus.pos !== 8'h00 || bus.dir !== 1'b1 || bus.err !== 1'b0 || bus.err_cnt !== 4'h0 || bus.seg !== 7'b1000000)
      begin errors++; $display("FAIL rstf_out: got pos %h dir %b err %b cnt %h seg %b", bus.pos, bus.dir, bus.err, bus.err_cnt, bus.seg); end
    // q_in still 10 at release: first sample compares against 00
    rst_n = 1'b1;
    hold(6);
    checks++; if (bus.pos !== 8'h01 || step_cnt - s0 !== 1) begin errors++; $display("FAIL rstf_post: got pos %h steps %0d exp 01 1", bus.pos, step_cnt - s0); end
  endtask

  task automatic test_upstream();
    logic [1:0] gseq [4];
    gseq = '{2'b00, 2'b10, 2'b11, 2'b01};
    do_reset();
    hold(4);
    #3;
    for (int i = 1; i <= 100; i++) begin
      #173 bus.q_in = gseq[i % 4];
    end
    hold(8);
    checks++; if (bus.pos !== 8'h64) begin errors++; $display("FAIL up_pos: got %h exp 64", bus.pos); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL up_err: got %b exp 0", bus.err); end
    checks++; if (bus.seg !== 7'b0011001) begin errors++; $display("FAIL up_seg: got %b exp 0011001", bus.seg); end
  endtask

  initial begin
    bus.q_in = 2'b00;
    bus.clr  = 1'b0;
    test_reset();
    test_forward();
    test_backward_wrap();
    test_illegal();
    test_clear_collision();
    test_latency_reset();
    test_upstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_step_monitor.md
GRAY_STEP_MONITOR -- requirements
Module: gray_step_monitor

Interface
REQ-001 Parameter POS_W, default 8, width of the position counter pos.
REQ-002 Parameter ERR_CNT_W, default 4, width of the saturating error counter err_cnt.
REQ-003 Port clk_50M  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port q_in  input  2  2-bit Gray count from the upstream mod-4 counter; clocked by the divided clock; asynchronous to clk_50M.
REQ-006 Port clr  input  1  synchronous clear of pos, err, err_cnt; active-high.
REQ-007 Port step_p  output  1  one-cycle pulse per valid single step.
REQ-008 Port dir  output  1  direction of last valid step; 1=forward, 0=backward.
REQ-009 Port pos  output  POS_W  signed-free wrapping step position.
REQ-010 Port err  output  1  sticky illegal-transition flag.
REQ-011 Port err_cnt  output  ERR_CNT_W  count of illegal transitions, saturating.
REQ-012 Port seg  output  7  active-low seven-segment pattern (g..a) of pos[3:0] as hex 0-F.

Function
REQ-013 q_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a previous-value register s3; no other logic reads q_in.
REQ-014 Gray-to-index map SHALL be: 00->0, 10->1, 11->2, 01->3.
REQ-015 Each clk_50M cycle, idx(s2) vs idx(s3): equal -> no event; +1 mod 4 -> forward step; -1 mod 4 -> backward step; +2 mod 4 -> illegal.
REQ-016 Forward step: pos <= pos+1, wraps from 2^POS_W-1 to 0; dir <= 1; step_p <= 1 for exactly one cycle.
REQ-017 Backward step: pos <= pos-1, wraps from 0 to 2^POS_W-1; dir <= 0; step_p <= 1 for exactly one cycle.
REQ-018 Illegal: err <= 1 (held); err_cnt <= err_cnt+1 unless all-ones (saturates); pos, dir unchanged; step_p stays 0.
REQ-019 s3 SHALL update to s2 every cycle regardless of event type, so each transition is evaluated once.
REQ-020 Latency: q_in change captured at edge N appears on pos/step_p/err after edge N+2 (3 edges incl. capture).
REQ-021 clr=1: pos, err, err_cnt <= 0 at that edge; any step or illegal event in the same cycle is discarded; dir unchanged; step_p <= 0; s1-s3 keep sampling.
REQ-022 Outputs step_p, dir, pos, err, err_cnt SHALL be registered; seg is combinational decode of registered pos[3:0].
REQ-023 seg SHALL encode 0-9, A, b, C, d, E, F with standard segment patterns, segment active when bit=0.

Reset
REQ-024 rst_n=0 SHALL immediately set s1, s2, s3 <= 00, pos <= 0, dir <= 1, step_p <= 0, err <= 0, err_cnt <= 0; seg thereby shows "0" (7'b1000000).
REQ-025 Reset assertion mid-operation SHALL abort any in-flight transition; the first post-reset sample of q_in is compared against 00.
REQ-026 Release of rst_n SHALL require no extra cycles; first evaluation occurs on the first clk_50M edge after release.

Verification
REQ-027 Forward run: reset, q_in sequence 00->10->11->01->00 each held 8 cycles -> 4 step_p pulses, dir=1, pos=4, err=0, seg=7'b0011001.
REQ-028 Backward and wrap: from reset, q_in 00->01 held 8 cycles -> pos=8'hFF, dir=0, one step_p; then 01->00 -> pos=0.
REQ-029 Illegal jump: q_in 00->11 -> err=1, err_cnt=1, pos=0, no step_p; repeat 00/11 toggle 20 times -> err_cnt=4'hF (saturated).
REQ-030 Clear collision: pos=5, err=1, assert clr on the same cycle a forward step is evaluated -> pos=0, err=0, err_cnt=0, step_p=0; next step gives pos=1.
REQ-031 Latency/reset: q_in change at edge N -> step_p high exactly in cycle after edge N+2; assert rst_n low at edge N+1 -> no step_p, pos=0, all outputs at reset values.
REQ-032 Upstream-linked run: drive q_in from the mod-4 Gray counter clocked by its divided clock for 100 upstream periods -> pos=100 (8'h64), err=0.
